// File: rtl/sound_mixer_pipe.sv
// Time-multiplexed stereo mixer for the sound unit.
// One channel per cycle through a DAC model, pan, master volume and DC-blocking HPF.
module sound_mixer_pipe #(
    parameter int NCH       = 4,
    parameter int CW        = 4,
    parameter int OW        = 20,
    parameter int HPF_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sound_enable,
    input  logic              sample_tick,
    input  logic [NCH*CW-1:0] levels,
    input  logic [NCH-1:0]    dac_en,
    input  logic [NCH-1:0]    pan_l,
    input  logic [NCH-1:0]    pan_r,
    input  logic [2:0]        vol_l,
    input  logic [2:0]        vol_r,
    input  logic              hpf_en,
    input  logic              overrun_clr,
    output logic [OW-1:0]     left,
    output logic [OW-1:0]     right,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW  = CW + 2;
    localparam int SW  = CW + 2 + $clog2(NCH);
    localparam int MW  = SW + 3;
    localparam int YW  = MW + 1;
    localparam int CPW = MW + HPF_SHIFT + 1;

    localparam logic [DW-1:0] DOFF = DW'((1 << CW) - 1);
    localparam logic signed [CPW-1:0] YMAX = CPW'((1 << (YW - 1)) - 1);
    localparam logic signed [CPW-1:0] YMIN = ~YMAX;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        SCALE,
        FILT,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]  idx;
    logic [NCH-1:0] dac_en_s;
    logic [NCH-1:0] pan_l_s;
    logic [NCH-1:0] pan_r_s;
    logic [2:0]     vol_l_s;
    logic [2:0]     vol_r_s;
    logic           hpf_s;

    logic signed [SW-1:0]  acc_l;
    logic signed [SW-1:0]  acc_r;
    logic signed [MW-1:0]  m_l;
    logic signed [MW-1:0]  m_r;
    logic signed [CPW-1:0] cap_l;
    logic signed [CPW-1:0] cap_r;

    logic [CW-1:0]         lvl;
    logic                  ch_en;
    logic                  ch_pl;
    logic                  ch_pr;
    logic signed [DW-1:0]  dac_raw;
    logic signed [DW-1:0]  dac;
    logic signed [SW-1:0]  dac_ext;
    logic signed [MW-1:0]  gain_l;
    logic signed [MW-1:0]  gain_r;
    logic signed [CPW-1:0] y_l;
    logic signed [CPW-1:0] y_r;

    logic start;
    logic last_ch;

    // High-pass step: subtract the leaked capacitor charge, or pass through.
    function automatic logic signed [CPW-1:0] hp_step(
        input logic signed [MW-1:0]  m,
        input logic signed [CPW-1:0] cap,
        input logic                  en
    );
        logic signed [CPW-1:0] m_ext;
        m_ext = CPW'(m);
        if (en) begin
            return m_ext - (cap >>> HPF_SHIFT);
        end
        return m_ext;
    endfunction

    // Clamp the filter output to the sample range and left-justify it.
    function automatic logic [OW-1:0] sat_just(
        input logic signed [CPW-1:0] y
    );
        logic signed [YW-1:0] ys;
        if (y > YMAX) begin
            ys = YW'(YMAX);
        end else if (y < YMIN) begin
            ys = YW'(YMIN);
        end else begin
            ys = YW'(y);
        end
        return OW'(ys) << (OW - YW);
    endfunction

    assign busy    = (state != IDLE);
    assign start   = sample_tick && sound_enable && (state == IDLE);
    assign last_ch = (idx == IW'(NCH - 1));

    // Select the current channel's level and its snapshotted routing bits.
    always_comb begin
        lvl   = '0;
        ch_en = 1'b0;
        ch_pl = 1'b0;
        ch_pr = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) begin
                lvl   = levels[i*CW +: CW];
                ch_en = dac_en_s[i];
                ch_pl = pan_l_s[i];
                ch_pr = pan_r_s[i];
            end
        end
    end

    // DAC model: unsigned level mapped to a symmetric signed value.
    always_comb begin
        dac_raw = $signed({1'b0, lvl, 1'b0} - DOFF);
        dac     = ch_en ? dac_raw : '0;
        dac_ext = SW'(dac);
    end

    // Master gain and filter outputs for both sides.
    always_comb begin
        gain_l = MW'(vol_l_s) + MW'(1);
        gain_r = MW'(vol_r_s) + MW'(1);
        y_l    = hp_step(m_l, cap_l, hpf_s);
        y_r    = hp_step(m_r, cap_r, hpf_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; disabling the unit always returns to idle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ACC;
            ACC:     if (last_ch) state_nx = SCALE;
            SCALE:   state_nx = FILT;
            FILT:    state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!sound_enable) begin
            state_nx = IDLE;
        end
    end

    // Datapath: snapshot, accumulate, scale, filter and publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            dac_en_s  <= '0;
            pan_l_s   <= '0;
            pan_r_s   <= '0;
            vol_l_s   <= '0;
            vol_r_s   <= '0;
            hpf_s     <= 1'b0;
            acc_l     <= '0;
            acc_r     <= '0;
            m_l       <= '0;
            m_r       <= '0;
            cap_l     <= '0;
            cap_r     <= '0;
            left      <= '0;
            right     <= '0;
            out_valid <= 1'b0;
        end else if (!sound_enable) begin
            cap_l     <= '0;
            cap_r     <= '0;
            left      <= '0;
            right     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == FILT);
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        dac_en_s <= dac_en;
                        pan_l_s  <= pan_l;
                        pan_r_s  <= pan_r;
                        vol_l_s  <= vol_l;
                        vol_r_s  <= vol_r;
                        hpf_s    <= hpf_en;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        idx      <= '0;
                    end
                end
                ACC: begin
                    idx <= idx + IW'(1);
                    if (ch_pl) acc_l <= acc_l + dac_ext;
                    if (ch_pr) acc_r <= acc_r + dac_ext;
                end
                SCALE: begin
                    m_l <= MW'(acc_l) * gain_l;
                    m_r <= MW'(acc_r) * gain_r;
                end
                FILT: begin
                    cap_l <= hpf_s ? cap_l + y_l : '0;
                    cap_r <= hpf_s ? cap_r + y_r : '0;
                    left  <= sat_just(y_l);
                    right <= sat_just(y_r);
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky overrun flag; a dropped tick wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (sound_enable && sample_tick && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sound_mixer_pipe.sv
// Directed bench for sound_mixer_pipe.
// Hand-computed samples, latency, overrun and enable behaviour.
module tb_sound_mixer_pipe;

    logic        clk;
    logic        rst;
    logic        sound_enable;
    logic        sample_tick;
    logic [15:0] levels;
    logic [3:0]  dac_en;
    logic [3:0]  pan_l;
    logic [3:0]  pan_r;
    logic [2:0]  vol_l;
    logic [2:0]  vol_r;
    logic        hpf_en;
    logic        overrun_clr;
    logic [19:0] left;
    logic [19:0] right;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_chk;
    int n_pass;

    sound_mixer_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .sound_enable (sound_enable),
        .sample_tick  (sample_tick),
        .levels       (levels),
        .dac_en       (dac_en),
        .pan_l        (pan_l),
        .pan_r        (pan_r),
        .vol_l        (vol_l),
        .vol_r        (vol_r),
        .hpf_en       (hpf_en),
        .overrun_clr  (overrun_clr),
        .left         (left),
        .right        (right),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Tick in cycle t, then expect busy, valid at t+7 and one-cycle strobe.
    task automatic run_sample(input string tag, input longint exp_l,
                              input longint exp_r);
        int lat;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check({tag, ".busy"}, longint'(busy), 1);
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, 7);
        check({tag, ".left"}, longint'($signed(left)), exp_l);
        check({tag, ".right"}, longint'($signed(right)), exp_r);
        @(negedge clk);
        check({tag, ".vdrop"}, longint'(out_valid), 0);
    endtask

    task automatic set_single();
        levels = 16'h999F;
        dac_en = 4'b0001;
        pan_l  = 4'b0001;
        pan_r  = 4'b0000;
        vol_l  = 3'd7;
        vol_r  = 3'd0;
    endtask

    initial begin
        int lat;
        int nv;
        int hp[6];
        hp = '{120, 113, 106, 99, 93, 87};
        n_chk        = 0;
        n_pass       = 0;
        rst          = 1'b1;
        sound_enable = 1'b1;
        sample_tick  = 1'b0;
        levels       = '0;
        dac_en       = '0;
        pan_l        = '0;
        pan_r        = '0;
        vol_l        = '0;
        vol_r        = '0;
        hpf_en       = 1'b0;
        overrun_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.left", longint'(left), 0);
        check("rst.right", longint'(right), 0);
        check("rst.valid", longint'(out_valid), 0);
        check("rst.busy", longint'(busy), 0);
        check("rst.ovr", longint'(overrun), 0);
        rst = 1'b0;
        @(negedge clk);

        set_single();
        run_sample("single", 30720, 0);

        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.busy", longint'(busy), 0);
        check("midrst.left", longint'(left), 0);
        check("midrst.valid", longint'(out_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        run_sample("postrst", 30720, 0);

        levels = 16'h0000;
        dac_en = 4'b1111;
        pan_l  = 4'b1111;
        pan_r  = 4'b1111;
        vol_l  = 3'd0;
        vol_r  = 3'd1;
        run_sample("offset", -15360, -30720);

        set_single();
        hpf_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_sample($sformatf("hpf%0d", i), hp[i] * 256, 0);
            repeat (4) @(negedge clk);
        end
        hpf_en = 1'b0;
        run_sample("hpfoff", 30720, 0);

        check("ovr.pre", longint'(overrun), 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("ovr.t1", longint'(overrun), 0);
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("ovr.t4", longint'(overrun), 1);
        lat = 4;
        while (!out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check("ovr.lat", lat, 7);
        check("ovr.left", longint'($signed(left)), 30720);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("ovr.extra", nv, 0);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr.clr", longint'(overrun), 0);
        sample_tick = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("ovr.setwins", longint'(overrun), 1);
        repeat (10) @(negedge clk);

        hpf_en = 1'b1;
        run_sample("dis.a", 30720, 0);
        run_sample("dis.b", 113 * 256, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        sound_enable = 1'b0;
        @(negedge clk);
        check("dis.busy", longint'(busy), 0);
        check("dis.left", longint'(left), 0);
        check("dis.right", longint'(right), 0);
        check("dis.valid", longint'(out_valid), 0);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("dis.novalid", nv, 0);
        sound_enable = 1'b1;
        @(negedge clk);
        run_sample("reen", 30720, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
